// File: rtl/bayer_demosaic_param.sv
// bayer_demosaic_param: 3x3 Bayer-to-RGB demosaic with mirrored borders and a per-frame phase latch
// Ports: BAYER_CLK, reset (async, active-high); BAYER_X/Y/DATA/VALID/PATTERN raster raw input;
//        RGB_R/G/B/X/Y/VALID/SOF/EOF window-centre output two clocks after acceptance;
//        RGB_FRAME_COUNT completed output frames.
// Option macro: DEMOSAIC_EDGE_GREEN_EN selects edge-directed green at R and B sites.
module bayer_demosaic_param #(
    parameter int DATA_W  = 12,
    parameter int VIDEO_W = 800,
    parameter int VIDEO_H = 600
) (
    input  logic              BAYER_CLK,
    input  logic              reset,
    input  logic [11:0]       BAYER_X,
    input  logic [11:0]       BAYER_Y,
    input  logic [DATA_W-1:0] BAYER_DATA,
    input  logic              BAYER_VALID,
    input  logic [1:0]        BAYER_PATTERN,
    output logic [DATA_W-1:0] RGB_R,
    output logic [DATA_W-1:0] RGB_G,
    output logic [DATA_W-1:0] RGB_B,
    output logic [11:0]       RGB_X,
    output logic [11:0]       RGB_Y,
    output logic              RGB_VALID,
    output logic              RGB_SOF,
    output logic              RGB_EOF,
    output logic [19:0]       RGB_FRAME_COUNT
);
    localparam int AW = (VIDEO_W > 1) ? $clog2(VIDEO_W) : 1;
    localparam logic [11:0] LAST_X = 12'(VIDEO_W - 2);
    localparam logic [11:0] LAST_Y = 12'(VIDEO_H - 2);
    typedef logic [DATA_W-1:0] pix_t;
    // column index 0 = line-2 (top), 2 = current line (bottom)
    typedef logic [2:0][DATA_W-1:0] col_t;
    // window [row][col], col 0 = left, 2 = newest (right)
    typedef logic [2:0][2:0][DATA_W-1:0] win_t;

    function automatic pix_t avg2(pix_t a, pix_t b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
        return s[DATA_W:1];
    endfunction

    function automatic pix_t avg4(pix_t a, pix_t b, pix_t c, pix_t d);
        logic [DATA_W+1:0] s;
        s = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d} + (DATA_W+2)'(2);
        return s[DATA_W+1:2];
    endfunction

    pix_t lb1_q [VIDEO_W];
    pix_t lb2_q [VIDEO_W];
    logic [AW-1:0] addr;
    assign addr = BAYER_X[AW-1:0];

    logic        sof_in;
    logic        synced_q, synced_d;
    logic [1:0]  pat_q, pat_d;
    logic        s1_v_q, s1_v_d, s1_sync_q, s1_sync_d;
    logic [11:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [1:0]  s1_pat_q, s1_pat_d;
    col_t        col_q, col_d;
    win_t        win_q, win_d, m;
    logic        s2_v_q, s2_v_d;
    logic [11:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic [1:0]  s2_pat_q, s2_pat_d, site;
    pix_t        n, s, w, e, c, g4, d4, h2, v2, g_rb;
    pix_t        o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
    logic [11:0] o_x_q, o_x_d, o_y_q, o_y_d;
    logic        o_v_q, o_v_d, o_sof_q, o_sof_d, o_eof_q, o_eof_d;
    logic [19:0] fc_q, fc_d;
`ifdef DEMOSAIC_EDGE_GREEN_EN
    pix_t        dh, dv;
`endif

    always_comb begin
        sof_in    = BAYER_VALID && BAYER_X == '0 && BAYER_Y == '0;
        synced_d  = synced_q | sof_in;
        pat_d     = sof_in ? BAYER_PATTERN : pat_q;
        s1_v_d    = BAYER_VALID;
        s1_sync_d = synced_d;
        s1_pat_d  = pat_d;
        s1_x_d    = BAYER_VALID ? BAYER_X : s1_x_q;
        s1_y_d    = BAYER_VALID ? BAYER_Y : s1_y_q;
        col_d     = BAYER_VALID ? {BAYER_DATA, lb1_q[addr], lb2_q[addr]} : col_q;
        win_d = win_q;
        if (s1_v_q)
            for (int r = 0; r < 3; r++) win_d[r] = {col_q[r], win_q[r][2:1]};
        // the pixel just shifted in is the right column; the centre sits one column and one line back
        s2_v_d   = s1_v_q && s1_sync_q && s1_x_q != '0 && s1_y_q != '0;
        s2_x_d   = s1_x_q - 12'd1;
        s2_y_d   = s1_y_q - 12'd1;
        s2_pat_d = s1_pat_q;
        // borders reuse the opposite neighbour, which has the same Bayer colour
        m = win_q;
        if (s2_y_q == '0) m[0] = m[2];
        if (s2_x_q == '0)
            for (int r = 0; r < 3; r++) m[r][0] = m[r][2];
        n  = m[0][1];
        s  = m[2][1];
        w  = m[1][0];
        e  = m[1][2];
        c  = m[1][1];
        g4 = avg4(n, s, e, w);
        d4 = avg4(m[0][0], m[0][2], m[2][0], m[2][2]);
        h2 = avg2(w, e);
        v2 = avg2(n, s);
`ifdef DEMOSAIC_EDGE_GREEN_EN
        dh   = w > e ? w - e : e - w;
        dv   = n > s ? n - s : s - n;
        g_rb = dh < dv ? h2 : (dv < dh ? v2 : g4);
`else
        g_rb = g4;
`endif
        // 00 R, 11 B, 01 G on an R row, 10 G on a B row
        site    = {s2_y_q[0], s2_x_q[0]} ^ s2_pat_q;
        o_r_d   = !s2_v_q ? '0 : site == 2'b00 ? c : site == 2'b11 ? d4 : site == 2'b01 ? h2 : v2;
        o_g_d   = !s2_v_q ? '0 : ^site ? c : g_rb;
        o_b_d   = !s2_v_q ? '0 : site == 2'b11 ? c : site == 2'b00 ? d4 : site == 2'b01 ? v2 : h2;
        o_v_d   = s2_v_q;
        o_x_d   = s2_x_q;
        o_y_d   = s2_y_q;
        o_sof_d = s2_v_q && s2_x_q == '0 && s2_y_q == '0;
        o_eof_d = s2_v_q && s2_x_q == LAST_X && s2_y_q == LAST_Y;
        fc_d    = fc_q + 20'(o_v_q & o_eof_q);
    end

    always_ff @(posedge BAYER_CLK)
        if (BAYER_VALID) begin
            lb1_q[addr] <= BAYER_DATA;
            lb2_q[addr] <= lb1_q[addr];
        end

    always_ff @(posedge BAYER_CLK or posedge reset)
        if (reset) begin
            synced_q  <= 1'b0;
            pat_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_sync_q <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_pat_q  <= '0;
            col_q     <= '0;
            win_q     <= '0;
            s2_v_q    <= 1'b0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
            s2_pat_q  <= '0;
            o_r_q     <= '0;
            o_g_q     <= '0;
            o_b_q     <= '0;
            o_x_q     <= '0;
            o_y_q     <= '0;
            o_v_q     <= 1'b0;
            o_sof_q   <= 1'b0;
            o_eof_q   <= 1'b0;
            fc_q      <= '0;
        end else begin
            synced_q  <= synced_d;
            pat_q     <= pat_d;
            s1_v_q    <= s1_v_d;
            s1_sync_q <= s1_sync_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_pat_q  <= s1_pat_d;
            col_q     <= col_d;
            win_q     <= win_d;
            s2_v_q    <= s2_v_d;
            s2_x_q    <= s2_x_d;
            s2_y_q    <= s2_y_d;
            s2_pat_q  <= s2_pat_d;
            o_r_q     <= o_r_d;
            o_g_q     <= o_g_d;
            o_b_q     <= o_b_d;
            o_x_q     <= o_x_d;
            o_y_q     <= o_y_d;
            o_v_q     <= o_v_d;
            o_sof_q   <= o_sof_d;
            o_eof_q   <= o_eof_d;
            fc_q      <= fc_d;
        end

    assign RGB_R           = o_r_q;
    assign RGB_G           = o_g_q;
    assign RGB_B           = o_b_q;
    assign RGB_X           = o_x_q;
    assign RGB_Y           = o_y_q;
    assign RGB_VALID       = o_v_q;
    assign RGB_SOF         = o_sof_q;
    assign RGB_EOF         = o_eof_q;
    assign RGB_FRAME_COUNT = fc_q;
endmodule
